mmu_seq_ctrl: RTL and testbench
===============================

Name: mmu_seq_ctrl

Overview:
Sequencer that drives the 16x16 systolic MMU for one tile job.
- Loads 16 weight rows from the weight buffer, with `mmu_wen` high.
- Streams N activation vectors from the activation buffer.
- Captures each 16-lane 20-bit result after a fixed MMU latency and writes it to the result buffer.
- Sits between the top-level command/CSR logic and the MMU plus its three on-chip SRAMs.

Parameters:
ARRAY_N, 16, MMU rows/columns and lanes per vector
D_W, 8, activation/weight lane width (signed)
ACC_W, 20, result lane width (signed)
ADDR_W, 8, buffer address width
MMU_LAT, 31, cycles from an activation vector on `mmu_ain` to its result on `mmu_aout`

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  job start pulse; sampled only in IDLE
w_base  in  ADDR_W  weight buffer start address
a_base  in  ADDR_W  activation buffer start address
r_base  in  ADDR_W  result buffer start address
num_vec  in  ADDR_W+1  activation vectors in the job (0..2^ADDR_W)
busy  out  1  job in progress
done  out  1  one-cycle pulse at job end
w_ren / w_addr  out  1 / ADDR_W  weight SRAM read
w_rdata  in  ARRAY_N*D_W  weight row; valid 1 cycle after w_ren
a_ren / a_addr  out  1 / ADDR_W  activation SRAM read
a_rdata  in  ARRAY_N*D_W  activation vector; valid 1 cycle after a_ren
r_wen / r_addr / r_wdata  out  1 / ADDR_W / ARRAY_N*ACC_W  result SRAM write
mmu_wen  out  1  MMU weight-load enable
mmu_win  out  ARRAY_N*D_W  MMU weight row
mmu_ain  out  ARRAY_N*D_W  MMU activation vector (zero when not valid)
mmu_aout  in  ARRAY_N*ACC_W  MMU result vector

Behaviour:
- Reset (async, `reset_n`=0):
  - state=IDLE.
  - All outputs 0: `busy`, `done`, `w_ren`, `a_ren`, `r_wen`, `mmu_wen`, all addresses and data buses.
  - Valid pipeline cleared.
  - A reset mid-job aborts the job; no further `r_wen` occurs.
- States: IDLE -> LOAD_W -> STREAM -> DRAIN -> IDLE.
- IDLE:
  - `start`=1 latches `w_base`, `a_base`, `r_base`, `num_vec`; next state LOAD_W; `busy`=1 from the next cycle.
  - `start` outside IDLE is ignored.
- LOAD_W: issue `w_ren` for exactly ARRAY_N cycles, `w_addr`=`w_base`+k (k=0..15, mod 2^ADDR_W).
- Weight path is 1-cycle registered: `mmu_win`=`w_rdata` and `mmu_wen`=1 in the cycle after each read. This gives exactly ARRAY_N consecutive `mmu_wen` cycles, row k before row k+1.
- After the 16th read issue: go to STREAM if `num_vec`>0, else DRAIN.
- STREAM:
  - Issue `a_ren` for `num_vec` consecutive cycles, `a_addr`=`a_base`+v (wrap).
  - `mmu_ain`=`a_rdata` one cycle later, with internal `ain_valid`=1.
  - The first `mmu_ain` cycle coincides with the cycle after the last `mmu_wen` cycle; there is no bubble and no overlap.
  - Then go to DRAIN.
- Valid tracking: a MMU_LAT-deep shift register of `ain_valid`. When its output is 1:
  - `r_wen`=1, `r_wdata`=`mmu_aout` (combinational capture, registered write port).
  - `r_addr`=`r_base`+count (wrap). count increments per write.
- DRAIN:
  - Wait until the valid shift register is empty and count=`num_vec`.
  - Then `done`=1 for one cycle; `busy`=0 in the same cycle; return to IDLE.
  - `num_vec`=0: `done` asserts the cycle after the last `mmu_wen` cycle; no `r_wen`.
- Throughput: one vector per cycle.
- Total job latency from `start` = 1 + 16 + `num_vec` + 1 + MMU_LAT + 1 cycles for `num_vec`>0.
- `mmu_ain` is forced to 0 whenever `ain_valid`=0.
- `mmu_win` holds its last value when `mmu_wen`=0.

Optional Feature:
MMU_SEQ_CTRL_RELU_EN
- Defined: each ACC_W lane of `r_wdata` is clamped so negative values (MSB=1) become 0 before the write. Clamping adds no latency.
- Undefined: `r_wdata` is a raw copy of `mmu_aout`.

Test Plan:
All scenarios use a bench MMU stub that latches weights on `mmu_wen` and returns the dot products MMU_LAT cycles after each `mmu_ain`.
- Reset then `start` with `w_base`=0, `a_base`=0, `r_base`=0, `num_vec`=1; all weights 1, activation all 2 -> exactly 16 `mmu_wen` cycles; one `r_wen` at `r_addr` 0; every lane=32; `done` at cycle 1+16+1+1+31+1=51 after `start`.
- `num_vec`=4, activations row v=-(v+1) in all lanes, weights all 1 -> `r_addr` 0..3 on consecutive cycles; lanes -16, -32, -48, -64.
- Same as the previous scenario with MMU_SEQ_CTRL_RELU_EN defined -> all four result rows are 0.
- `a_base`=254, `r_base`=255, `num_vec`=3 -> `a_addr` 254, 255, 0; `r_addr` 255, 0, 1.
- `num_vec`=0 -> 16 weight loads; no `a_ren` and no `r_wen`; `done` one cycle after the last `mmu_wen`. A `start` pulsed while `busy` is ignored.
- Assert `reset_n`=0 during STREAM of a `num_vec`=8 job -> all outputs 0 immediately; no `r_wen` after release; a new `start` then runs a full job correctly.

Source files
------------

// File: rtl/mmu_seq_ctrl.sv
// Tile-job sequencer for the 16x16 systolic MMU: weight load, activation stream, result capture.
// Define MMU_SEQ_CTRL_RELU_EN to clamp negative result lanes to zero before the result write.
module mmu_seq_ctrl #(
    parameter int ARRAY_N = 16,
    parameter int D_W     = 8,
    parameter int ACC_W   = 20,
    parameter int ADDR_W  = 8,
    parameter int MMU_LAT = 31
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        w_base,
    input  logic [ADDR_W-1:0]        a_base,
    input  logic [ADDR_W-1:0]        r_base,
    input  logic [ADDR_W:0]          num_vec,
    output logic                     busy,
    output logic                     done,
    output logic                     w_ren,
    output logic [ADDR_W-1:0]        w_addr,
    input  logic [ARRAY_N*D_W-1:0]   w_rdata,
    output logic                     a_ren,
    output logic [ADDR_W-1:0]        a_addr,
    input  logic [ARRAY_N*D_W-1:0]   a_rdata,
    output logic                     r_wen,
    output logic [ADDR_W-1:0]        r_addr,
    output logic [ARRAY_N*ACC_W-1:0] r_wdata,
    output logic                     mmu_wen,
    output logic [ARRAY_N*D_W-1:0]   mmu_win,
    output logic [ARRAY_N*D_W-1:0]   mmu_ain,
    input  logic [ARRAY_N*ACC_W-1:0] mmu_aout
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int K_W   = $clog2(ARRAY_N) + 1;

    typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_t;

    state_t                   state;
    logic [ADDR_W-1:0]        w_base_q;
    logic [ADDR_W-1:0]        a_base_q;
    logic [ADDR_W-1:0]        r_base_q;
    logic [CNT_W-1:0]         num_vec_q;
    logic [K_W-1:0]           k;
    logic [CNT_W-1:0]         v;
    logic [CNT_W-1:0]         count;
    logic                     ain_valid;
    logic [MMU_LAT-1:0]       vsr;
    logic [ARRAY_N*D_W-1:0]   win_hold;
    logic [ARRAY_N*ACC_W-1:0] wdata_next;

    // SRAM read data arrives one cycle after the request, so the MMU sees it as it lands.
    assign mmu_win = mmu_wen ? w_rdata : win_hold;
    assign mmu_ain = ain_valid ? a_rdata : '0;

    always_comb begin
        wdata_next = mmu_aout;
`ifdef MMU_SEQ_CTRL_RELU_EN
        for (int i = 0; i < ARRAY_N; i++) begin
            if (mmu_aout[i*ACC_W + ACC_W - 1])
                wdata_next[i*ACC_W +: ACC_W] = '0;
        end
`else
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            w_ren     <= 1'b0;
            w_addr    <= '0;
            a_ren     <= 1'b0;
            a_addr    <= '0;
            w_base_q  <= '0;
            a_base_q  <= '0;
            r_base_q  <= '0;
            num_vec_q <= '0;
            k         <= '0;
            v         <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        w_base_q  <= w_base;
                        a_base_q  <= a_base;
                        r_base_q  <= r_base;
                        num_vec_q <= num_vec;
                        busy      <= 1'b1;
                        w_ren     <= 1'b1;
                        w_addr    <= w_base;
                        k         <= K_W'(1);
                        state     <= LOAD_W;
                    end
                end
                LOAD_W: begin
                    if (k == K_W'(ARRAY_N)) begin
                        w_ren <= 1'b0;
                        if (num_vec_q != '0) begin
                            a_ren  <= 1'b1;
                            a_addr <= a_base_q;
                            v      <= CNT_W'(1);
                            state  <= STREAM;
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        w_addr <= w_base_q + ADDR_W'(k);
                        k      <= k + 1'b1;
                    end
                end
                STREAM: begin
                    if (v == num_vec_q) begin
                        a_ren <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        a_addr <= a_base_q + v[ADDR_W-1:0];
                        v      <= v + 1'b1;
                    end
                end
                DRAIN: begin
                    if (!ain_valid && (vsr == '0) && (count == num_vec_q)) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The valid shift register lines up each streamed vector with its result leaving the MMU.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mmu_wen   <= 1'b0;
            win_hold  <= '0;
            ain_valid <= 1'b0;
            vsr       <= '0;
            r_wen     <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            count     <= '0;
        end else begin
            mmu_wen   <= w_ren;
            ain_valid <= a_ren;
            vsr       <= {vsr[MMU_LAT-2:0], ain_valid};
            r_wen     <= vsr[MMU_LAT-1];
            if (mmu_wen)
                win_hold <= w_rdata;
            if (vsr[MMU_LAT-1]) begin
                r_wdata <= wdata_next;
                r_addr  <= r_base_q + count[ADDR_W-1:0];
                count   <= count + 1'b1;
            end
            if ((state == IDLE) && start)
                count <= '0;
        end
    end

endmodule

// File: tb/tb_mmu_seq_ctrl.sv
// Directed bench for mmu_seq_ctrl with SRAM and systolic-MMU behavioural stubs.
module tb_mmu_seq_ctrl;

    localparam int ARRAY_N = 16;
    localparam int D_W     = 8;
    localparam int ACC_W   = 20;
    localparam int ADDR_W  = 8;
    localparam int MMU_LAT = 31;
    localparam int VW      = ARRAY_N * D_W;
    localparam int RW      = ARRAY_N * ACC_W;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] w_base, a_base, r_base;
    logic [ADDR_W:0]   num_vec;
    logic              busy, done;
    logic              w_ren, a_ren, r_wen, mmu_wen;
    logic [ADDR_W-1:0] w_addr, a_addr, r_addr;
    logic [VW-1:0]     w_rdata, a_rdata, mmu_win, mmu_ain;
    logic [RW-1:0]     r_wdata, mmu_aout;

    mmu_seq_ctrl dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .w_base(w_base), .a_base(a_base), .r_base(r_base), .num_vec(num_vec),
        .busy(busy), .done(done),
        .w_ren(w_ren), .w_addr(w_addr), .w_rdata(w_rdata),
        .a_ren(a_ren), .a_addr(a_addr), .a_rdata(a_rdata),
        .r_wen(r_wen), .r_addr(r_addr), .r_wdata(r_wdata),
        .mmu_wen(mmu_wen), .mmu_win(mmu_win), .mmu_ain(mmu_ain), .mmu_aout(mmu_aout)
    );

    always #5 clk = ~clk;

    // SRAM stubs with one-cycle read latency
    logic [VW-1:0] wmem [256];
    logic [VW-1:0] amem [256];
    always @(posedge clk) begin
        if (w_ren) w_rdata <= wmem[w_addr];
        if (a_ren) a_rdata <= amem[a_addr];
    end

    // MMU stub: row k of weights multiplies activation lane k; result lane j is the column-j dot product
    logic [VW-1:0] wrow [ARRAY_N];
    logic [RW-1:0] pipe [MMU_LAT];
    logic [3:0]    row_idx;
    logic [RW-1:0] mmu_r;
    int            mmu_acc;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) row_idx <= '0;
        else if (mmu_wen) begin
            wrow[row_idx] <= mmu_win;
            row_idx       <= row_idx + 4'd1;
        end
    end
    always @(posedge clk) begin
        for (int j = 0; j < ARRAY_N; j++) begin
            mmu_acc = 0;
            for (int i = 0; i < ARRAY_N; i++)
                mmu_acc += $signed(mmu_ain[i*D_W +: D_W]) * $signed(wrow[i][j*D_W +: D_W]);
            mmu_r[j*ACC_W +: ACC_W] = mmu_acc[ACC_W-1:0];
        end
        pipe[0] <= mmu_r;
        for (int k = 1; k < MMU_LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign mmu_aout = pipe[MMU_LAT-1];

    logic [605:0] all_out;
    assign all_out = {busy, done, w_ren, a_ren, r_wen, mmu_wen, w_addr, a_addr, r_addr, r_wdata, mmu_win, mmu_ain};

    // Monitor: rel counts cycles since the edge that sampled start (1 = first busy cycle)
    int                ncyc = 0;
    int                base = 0;
    int                rel;
    int                wen_total = 0;
    int                last_wen_rel = 0;
    int                done_total = 0;
    int                done_rel = 0;
    logic              busy_at_done = 1'b1;
    logic [ADDR_W-1:0] a_addr_q [$];
    logic [ADDR_W-1:0] r_addr_q [$];
    logic [RW-1:0]     r_data_q [$];
    int                r_rel_q  [$];
    always @(negedge clk) begin
        ncyc++;
        rel = ncyc - base;
        if (mmu_wen) begin
            wen_total++;
            last_wen_rel = rel;
        end
        if (a_ren) a_addr_q.push_back(a_addr);
        if (r_wen) begin
            r_addr_q.push_back(r_addr);
            r_data_q.push_back(r_wdata);
            r_rel_q.push_back(rel);
        end
        if (done) begin
            done_total++;
            done_rel     = rel;
            busy_at_done = busy;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int wen0, a0, r0, d0;

    function automatic logic [RW-1:0] lanes20(input int val);
        logic [ACC_W-1:0] l;
        l = val[ACC_W-1:0];
        return {ARRAY_N{l}};
    endfunction

    function automatic logic [VW-1:0] lanes8(input int val);
        logic [D_W-1:0] b;
        b = val[D_W-1:0];
        return {ARRAY_N{b}};
    endfunction

    task automatic start_job(input int wb, input int ab, input int rb, input int nv);
        @(posedge clk); #1;
        w_base  = wb[ADDR_W-1:0];
        a_base  = ab[ADDR_W-1:0];
        r_base  = rb[ADDR_W-1:0];
        num_vec = nv[ADDR_W:0];
        wen0 = wen_total;
        a0   = a_addr_q.size();
        r0   = r_addr_q.size();
        d0   = done_total;
        start = 1'b1;
        @(posedge clk); #1;
        base  = ncyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int pulse_at);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk); #1;
            start = (i == pulse_at);
            if (done_total != d0) ok = 1'b1;
        end
        start = 1'b0;
        n_checks++;
        if (!ok) begin
            $display("[TB] FAIL done_timeout: done not seen, required within 200 cycles");
            n_fail++;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        start   = 1'b0;
        w_base  = '0; a_base = '0; r_base = '0; num_vec = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (all_out !== '0) begin
            $display("[TB] FAIL reset_outputs: got %0h required 0", all_out);
            n_fail++;
        end
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (all_out !== '0) begin
            $display("[TB] FAIL idle_outputs: got %0h required 0", all_out);
            n_fail++;
        end
    endtask

    task automatic test_single_vector;
        amem[0] = lanes8(2);
        start_job(0, 0, 0, 1);
        wait_done(-1);
        n_checks++;
        if (wen_total - wen0 !== 16) begin
            $display("[TB] FAIL single_wen_count: got %0d required 16", wen_total - wen0);
            n_fail++;
        end
        n_checks++;
        if (a_addr_q.size() - a0 !== 1 || a_addr_q[a0] !== 8'd0) begin
            $display("[TB] FAIL single_a_reads: got %0d reads required 1 at addr 0", a_addr_q.size() - a0);
            n_fail++;
        end
        n_checks++;
        if (r_addr_q.size() - r0 !== 1) begin
            $display("[TB] FAIL single_r_count: got %0d required 1", r_addr_q.size() - r0);
            n_fail++;
        end else begin
            n_checks++;
            if (r_addr_q[r0] !== 8'd0) begin
                $display("[TB] FAIL single_r_addr: got %0d required 0", r_addr_q[r0]);
                n_fail++;
            end
            n_checks++;
            if (r_data_q[r0] !== lanes20(32)) begin
                $display("[TB] FAIL single_r_data: got %0h required %0h", r_data_q[r0], lanes20(32));
                n_fail++;
            end
            n_checks++;
            if (r_rel_q[r0] !== 50) begin
                $display("[TB] FAIL single_r_cycle: got %0d required 50", r_rel_q[r0]);
                n_fail++;
            end
        end
        n_checks++;
        if (done_rel !== 51 || busy_at_done !== 1'b0) begin
            $display("[TB] FAIL single_done: got cycle %0d busy %0b required cycle 51 busy 0", done_rel, busy_at_done);
            n_fail++;
        end
        n_checks++;
        if (last_wen_rel !== 17) begin
            $display("[TB] FAIL single_last_wen: got cycle %0d required 17", last_wen_rel);
            n_fail++;
        end
    endtask

    task automatic test_negative_stream;
        int exp_val [4];
`ifdef MMU_SEQ_CTRL_RELU_EN
        exp_val = '{0, 0, 0, 0};
`else
        exp_val = '{-16, -32, -48, -64};
`endif
        for (int v = 0; v < 4; v++) amem[v] = lanes8(-(v + 1));
        start_job(0, 0, 0, 4);
        wait_done(-1);
        n_checks++;
        if (r_addr_q.size() - r0 !== 4) begin
            $display("[TB] FAIL neg_r_count: got %0d required 4", r_addr_q.size() - r0);
            n_fail++;
        end else begin
            for (int v = 0; v < 4; v++) begin
                n_checks++;
                if (r_addr_q[r0+v] !== v[ADDR_W-1:0] || r_rel_q[r0+v] !== 50 + v) begin
                    $display("[TB] FAIL neg_r_addr%0d: got addr %0d cycle %0d required addr %0d cycle %0d",
                             v, r_addr_q[r0+v], r_rel_q[r0+v], v, 50 + v);
                    n_fail++;
                end
                n_checks++;
                if (r_data_q[r0+v] !== lanes20(exp_val[v])) begin
                    $display("[TB] FAIL neg_r_data%0d: got %0h required %0h", v, r_data_q[r0+v], lanes20(exp_val[v]));
                    n_fail++;
                end
            end
        end
        n_checks++;
        if (done_rel !== 54) begin
            $display("[TB] FAIL neg_done: got cycle %0d required 54", done_rel);
            n_fail++;
        end
    endtask

    task automatic test_addr_wrap;
        logic [ADDR_W-1:0] exp_a [3];
        logic [ADDR_W-1:0] exp_r [3];
        int                exp_d [3];
        exp_a = '{8'd254, 8'd255, 8'd0};
        exp_r = '{8'd255, 8'd0, 8'd1};
        exp_d = '{48, 64, 80};
        amem[254] = lanes8(3);
        amem[255] = lanes8(4);
        amem[0]   = lanes8(5);
        start_job(0, 254, 255, 3);
        wait_done(-1);
        n_checks++;
        if (a_addr_q.size() - a0 !== 3 || r_addr_q.size() - r0 !== 3) begin
            $display("[TB] FAIL wrap_counts: got %0d reads %0d writes required 3 and 3",
                     a_addr_q.size() - a0, r_addr_q.size() - r0);
            n_fail++;
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (a_addr_q[a0+i] !== exp_a[i]) begin
                    $display("[TB] FAIL wrap_a_addr%0d: got %0d required %0d", i, a_addr_q[a0+i], exp_a[i]);
                    n_fail++;
                end
                n_checks++;
                if (r_addr_q[r0+i] !== exp_r[i] || r_data_q[r0+i] !== lanes20(exp_d[i])) begin
                    $display("[TB] FAIL wrap_r%0d: got addr %0d data %0h required addr %0d data %0h",
                             i, r_addr_q[r0+i], r_data_q[r0+i], exp_r[i], lanes20(exp_d[i]));
                    n_fail++;
                end
            end
        end
    endtask

    task automatic test_zero_vectors;
        start_job(0, 0, 0, 0);
        wait_done(5);
        repeat (60) @(posedge clk);
        #1;
        n_checks++;
        if (wen_total - wen0 !== 16) begin
            $display("[TB] FAIL zero_wen_count: got %0d required 16", wen_total - wen0);
            n_fail++;
        end
        n_checks++;
        if (a_addr_q.size() - a0 !== 0 || r_addr_q.size() - r0 !== 0) begin
            $display("[TB] FAIL zero_no_access: got %0d reads %0d writes required 0 and 0",
                     a_addr_q.size() - a0, r_addr_q.size() - r0);
            n_fail++;
        end
        n_checks++;
        if (done_rel !== 18 || last_wen_rel !== 17) begin
            $display("[TB] FAIL zero_done: got done %0d last wen %0d required 18 and 17", done_rel, last_wen_rel);
            n_fail++;
        end
        n_checks++;
        if (done_total - d0 !== 1 || busy !== 1'b0) begin
            $display("[TB] FAIL zero_start_ignored: got %0d done pulses busy %0b required 1 and 0",
                     done_total - d0, busy);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid_stream;
        int r1;
        for (int v = 0; v < 8; v++) amem[v] = lanes8(1);
        start_job(0, 0, 0, 8);
        repeat (19) @(posedge clk);
        #1;
        n_checks++;
        if (a_ren !== 1'b1) begin
            $display("[TB] FAIL abort_in_stream: got a_ren %0b required 1", a_ren);
            n_fail++;
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (all_out !== '0) begin
            $display("[TB] FAIL abort_outputs: got %0h required 0", all_out);
            n_fail++;
        end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        r1 = r_addr_q.size();
        repeat (60) @(posedge clk);
        #1;
        n_checks++;
        if (r_addr_q.size() !== r1 || busy !== 1'b0) begin
            $display("[TB] FAIL abort_no_write: got %0d writes busy %0b required 0 writes busy 0",
                     r_addr_q.size() - r1, busy);
            n_fail++;
        end
        amem[0] = lanes8(2);
        start_job(0, 0, 0, 1);
        wait_done(-1);
        n_checks++;
        if (r_addr_q.size() - r0 !== 1 || r_data_q[r0] !== lanes20(32) || r_addr_q[r0] !== 8'd0) begin
            $display("[TB] FAIL rerun_result: got %0d writes required 1 write of %0h at 0",
                     r_addr_q.size() - r0, lanes20(32));
            n_fail++;
        end
        n_checks++;
        if (done_rel !== 51 || wen_total - wen0 !== 16) begin
            $display("[TB] FAIL rerun_timing: got done %0d wen %0d required 51 and 16", done_rel, wen_total - wen0);
            n_fail++;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            wmem[i] = lanes8(1);
            amem[i] = '0;
        end
        test_reset();
        test_single_vector();
        test_negative_stream();
        test_addr_wrap();
        test_zero_vectors();
        test_reset_mid_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
